// File: rtl/alu_dispatch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_dispatch_if                                               |
// | Brief    : Command bus and multiplier side-channel for alu_dispatch.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface alu_dispatch_if;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;
    logic        err;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic        mult_start;
    logic        mult_done;
    logic [15:0] mult_result;

    modport slave (
        input  A, B, op, start, mult_done, mult_result,
        output done, result, err, mult_a, mult_b, mult_start
    );

    modport master (
        output A, B, op, start, mult_done, mult_result,
        input  done, result, err, mult_a, mult_b, mult_start
    );
endinterface
`default_nettype wire

// File: rtl/alu_dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_dispatch                                                  |
// | Brief    : Single-cycle ADD/AND/XOR plus MUL offloaded to an external    |
// |            multiplier with timeout; one done pulse per command.          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module alu_dispatch #(
    parameter int unsigned MUL_TIMEOUT = 15
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    alu_dispatch_if.slave  bus
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_MUL_BUSY = 2'd1;
    localparam logic [1:0] c_DRAIN    = 2'd2;

    localparam logic [2:0] c_OP_NOP = 3'b000;
    localparam logic [2:0] c_OP_ADD = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_XOR = 3'b011;
    localparam logic [2:0] c_OP_MUL = 3'b100;

    localparam logic [7:0] c_TIMEOUT = MUL_TIMEOUT[7:0];

    logic [1:0]  r_state;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_result;
    logic        r_mult_start;
    logic [7:0]  r_mult_a;
    logic [7:0]  r_mult_b;
    logic [7:0]  r_cnt;

    logic [1:0]  w_state_nx;
    logic        w_done_nx;
    logic        w_err_nx;
    logic [15:0] w_result_nx;
    logic        w_mult_start_nx;
    logic [7:0]  w_mult_a_nx;
    logic [7:0]  w_mult_b_nx;
    logic [7:0]  w_cnt_nx;
    logic [8:0]  w_sum;

    assign w_sum = {1'b0, bus.A} + {1'b0, bus.B};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_IDLE;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_result     <= 16'h0000;
            r_mult_start <= 1'b0;
            r_mult_a     <= 8'h00;
            r_mult_b     <= 8'h00;
            r_cnt        <= 8'h00;
        end else begin
            r_state      <= w_state_nx;
            r_done       <= w_done_nx;
            r_err        <= w_err_nx;
            r_result     <= w_result_nx;
            r_mult_start <= w_mult_start_nx;
            r_mult_a     <= w_mult_a_nx;
            r_mult_b     <= w_mult_b_nx;
            r_cnt        <= w_cnt_nx;
        end
    end

    // done/err are pulses: default low every cycle, result holds until the next completion
    always_comb begin
        w_state_nx      = r_state;
        w_done_nx       = 1'b0;
        w_err_nx        = 1'b0;
        w_result_nx     = r_result;
        w_mult_start_nx = r_mult_start;
        w_mult_a_nx     = r_mult_a;
        w_mult_b_nx     = r_mult_b;
        w_cnt_nx        = r_cnt;

        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        c_OP_NOP: ;
                        c_OP_ADD: begin
                            w_result_nx = {7'd0, w_sum};
                            w_done_nx   = 1'b1;
                            w_state_nx  = c_DRAIN;
                        end
                        c_OP_AND: begin
                            w_result_nx = {8'h00, bus.A & bus.B};
                            w_done_nx   = 1'b1;
                            w_state_nx  = c_DRAIN;
                        end
                        c_OP_XOR: begin
                            w_result_nx = {8'h00, bus.A ^ bus.B};
                            w_done_nx   = 1'b1;
                            w_state_nx  = c_DRAIN;
                        end
                        c_OP_MUL: begin
                            w_mult_a_nx     = bus.A;
                            w_mult_b_nx     = bus.B;
                            w_mult_start_nx = 1'b1;
                            w_cnt_nx        = 8'h00;
                            w_state_nx      = c_MUL_BUSY;
                        end
                        default: begin
                            w_result_nx = 16'h0000;
                            w_done_nx   = 1'b1;
                            w_err_nx    = 1'b1;
                            w_state_nx  = c_DRAIN;
                        end
                    endcase
                end
            end
            c_MUL_BUSY: begin
                // a completion arriving on the timeout cycle still counts as success
                if (bus.mult_done) begin
                    w_result_nx     = bus.mult_result;
                    w_done_nx       = 1'b1;
                    w_mult_start_nx = 1'b0;
                    w_state_nx      = c_DRAIN;
                end else if (r_cnt >= c_TIMEOUT) begin
                    w_result_nx     = 16'h0000;
                    w_done_nx       = 1'b1;
                    w_err_nx        = 1'b1;
                    w_mult_start_nx = 1'b0;
                    w_state_nx      = c_DRAIN;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            c_DRAIN: begin
                if (!bus.start) begin
                    w_state_nx = c_IDLE;
                end
            end
            default: begin
                w_state_nx = c_IDLE;
            end
        endcase
    end

    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.result     = r_result;
    assign bus.mult_start = r_mult_start;
    assign bus.mult_a     = r_mult_a;
    assign bus.mult_b     = r_mult_b;

endmodule
`default_nettype wire

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 A  input  8  operand A, sampled in IDLE when start=1.
REQ-005 B  input  8  operand B, sampled in IDLE when start=1.
REQ-006 op  input  3  opcode: 000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL, 101-111 illegal.
REQ-007 start  input  1  command request, held high by the requester until done.
REQ-008 done  output  1  registered one-cycle completion pulse.
REQ-009 result  output  16  registered result, valid while done=1 and held until the next completion.
REQ-010 err  output  1  registered error flag, valid with done (illegal op or multiplier timeout).
REQ-011 mult_a  output  8  captured operand A toward the three-cycle multiplier.
REQ-012 mult_b  output  8  captured operand B toward the three-cycle multiplier.
REQ-013 mult_start  output  1  registered multiplier request, high throughout MUL_BUSY.
REQ-014 mult_done  input  1  multiplier completion pulse.
REQ-015 mult_result  input  16  multiplier product, valid when mult_done=1.
REQ-016 Parameter MUL_TIMEOUT, default 15, sets the maximum MUL_BUSY cycles before timeout (legal range 4..255).

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, MUL_BUSY, DRAIN.
REQ-018 In IDLE with start=1 and op=NOP, the block SHALL stay in IDLE with no done and no state change.
REQ-019 In IDLE with start=1 and op in {ADD, AND, XOR}, the block SHALL, at the next edge, load result (ADD: zero-extended 9-bit sum; AND/XOR: {8'h00, A op B}), set done=1 and err=0, and enter DRAIN.
REQ-020 In IDLE with start=1 and op=MUL, the block SHALL, at the next edge, capture A/B into mult_a/mult_b, set mult_start=1, clear the timeout counter, and enter MUL_BUSY.
REQ-021 In IDLE with start=1 and op illegal, the block SHALL, at the next edge, set result=0, done=1 and err=1, and enter DRAIN.
REQ-022 In MUL_BUSY, mult_a/mult_b SHALL stay constant and the timeout counter SHALL increment each cycle mult_done=0.
REQ-023 In MUL_BUSY with mult_done=1, the block SHALL, at the next edge, load result=mult_result, set done=1, err=0 and mult_start=0, and enter DRAIN.
REQ-024 In MUL_BUSY, if the counter reaches MUL_TIMEOUT with mult_done=0, the block SHALL, at the next edge, set result=0, done=1, err=1 and mult_start=0, and enter DRAIN.
REQ-025 If mult_done=1 in the same cycle the counter reaches MUL_TIMEOUT, mult_done SHALL win (err=0).
REQ-026 mult_done SHALL be ignored outside MUL_BUSY.
REQ-027 done SHALL be high for exactly one cycle per accepted command; err SHALL be 0 whenever done=0.
REQ-028 In DRAIN, the block SHALL return to IDLE at the first edge where start=0; a command held with start=1 SHALL NOT retrigger.
REQ-029 Completion latency SHALL be: single-cycle ops 1 cycle (start sampled to done); MUL 1 + N + 1 cycles, where N is the cycle count from mult_start rising to mult_done.
REQ-030 A/B/op changes while not in IDLE SHALL have no effect.

Reset
REQ-031 On reset_n=0, the block SHALL immediately force state=IDLE, done=0, err=0, result=0, mult_start=0, mult_a=0, mult_b=0 and counter=0, regardless of the current state.
REQ-032 Reset asserted mid-MUL_BUSY SHALL abandon the command, with no done pulse after release.
REQ-033 After reset_n deasserts, the first command SHALL be accepted at the first clock edge at which start=1.

Verification
REQ-034 ADD A=8'hFF B=8'h01, start held -> done pulse 1 cycle later, result=16'h0100, err=0; no second done while start stays high.
REQ-035 XOR A=8'hA5 B=8'h0F -> result=16'h00AA; then AND A=8'hF0 B=8'h3C issued after start low for 1 cycle -> result=16'h0030.
REQ-036 MUL A=8'hFF B=8'hFF with the multiplier attached -> mult_start high until mult_done, result=16'hFE01, err=0, done 1 cycle after mult_done.
REQ-037 MUL with mult_done tied 0 -> done with err=1 and result=0 after MUL_TIMEOUT+1 cycles in MUL_BUSY; mult_start drops with done.
REQ-038 op=3'b110 -> done, err=1, result=0; op=NOP with start high for 5 cycles -> no done, state IDLE.
REQ-039 reset_n pulsed low during MUL_BUSY -> all outputs 0 immediately; no done after release; next ADD 2+3 -> result=16'h0005.
